// File: rtl/estagio_id_ex.sv
// ID/EX pipeline register: captures decoded fields, precomputes the ALU
// select and resolves EX/MEM and MEM/WB forwarding for both operands.
module estagio_id_ex #(
  parameter int LARGURA  = 8,
  parameter int BITS_REG = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                paralisar,
  input  logic                descartar,
  input  logic                valido_id,
  input  logic [LARGURA-1:0]  dado1_id,
  input  logic [LARGURA-1:0]  dado2_id,
  input  logic [BITS_REG-1:0] rs_id,
  input  logic [BITS_REG-1:0] rt_id,
  input  logic [BITS_REG-1:0] rd_id,
  input  logic                escreve_reg_id,
  input  logic                usa_imediato_id,
  input  logic [3:0]          imediato_id,
  input  logic [1:0]          op_ula_id,
  input  logic [2:0]          funct_id,
  input  logic                ex_mem_escreve,
  input  logic [BITS_REG-1:0] ex_mem_rd,
  input  logic [LARGURA-1:0]  ex_mem_resultado,
  input  logic                mem_wb_escreve,
  input  logic [BITS_REG-1:0] mem_wb_rd,
  input  logic [LARGURA-1:0]  mem_wb_dado,
  output logic [LARGURA-1:0]  entrada1,
  output logic [LARGURA-1:0]  entrada2,
  output logic [2:0]          sinal_ula,
  output logic                valido_ex,
  output logic [BITS_REG-1:0] rd_ex,
  output logic                escreve_reg_ex
);

  logic                valido_q, valido_d;
  logic [LARGURA-1:0]  dado1_q, dado1_d;
  logic [LARGURA-1:0]  dado2_q, dado2_d;
  logic [BITS_REG-1:0] rs_q, rs_d;
  logic [BITS_REG-1:0] rt_q, rt_d;
  logic [BITS_REG-1:0] rd_q, rd_d;
  logic                escreve_q, escreve_d;
  logic                usa_imm_q, usa_imm_d;
  logic [3:0]          imm_q, imm_d;
  logic [2:0]          sinal_q, sinal_d;

  logic [LARGURA-1:0]  fwd1, fwd2;
  logic [2:0]          sinal_dec;

  // Forwarding: r0 is hardwired zero; youngest producer (EX/MEM) wins.
  always_comb begin
    fwd1 = dado1_q;
    if (rs_q == '0)                              fwd1 = '0;
    else if (ex_mem_escreve && ex_mem_rd == rs_q) fwd1 = ex_mem_resultado;
    else if (mem_wb_escreve && mem_wb_rd == rs_q) fwd1 = mem_wb_dado;

    fwd2 = dado2_q;
    if (rt_q == '0)                              fwd2 = '0;
    else if (ex_mem_escreve && ex_mem_rd == rt_q) fwd2 = ex_mem_resultado;
    else if (mem_wb_escreve && mem_wb_rd == rt_q) fwd2 = mem_wb_dado;
  end

  // ALU select decode from operation class; unknown functs map to 111 (zero result).
  always_comb begin
    sinal_dec = 3'b010;
    case (op_ula_id)
      2'b00: sinal_dec = 3'b010;
      2'b01: sinal_dec = 3'b011;
      2'b11: sinal_dec = 3'b100;
      2'b10: sinal_dec = (funct_id <= 3'b100) ? funct_id : 3'b111;
      default: sinal_dec = 3'b010;
    endcase
  end

  // Next-state: flush > stall > load (reset handled in the flop block).
  always_comb begin
    valido_d  = valido_q;
    dado1_d   = dado1_q;
    dado2_d   = dado2_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    escreve_d = escreve_q;
    usa_imm_d = usa_imm_q;
    imm_d     = imm_q;
    sinal_d   = sinal_q;
    if (descartar) begin
      valido_d  = 1'b0;
      dado1_d   = '0;
      dado2_d   = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      escreve_d = 1'b0;
      usa_imm_d = 1'b0;
      imm_d     = '0;
      sinal_d   = '0;
    end else if (paralisar) begin
      // Absorb writebacks retiring during the stall so they are not lost.
      dado1_d = fwd1;
      dado2_d = fwd2;
    end else begin
      valido_d  = valido_id;
      dado1_d   = dado1_id;
      dado2_d   = dado2_id;
      rs_d      = rs_id;
      rt_d      = rt_id;
      rd_d      = rd_id;
      escreve_d = escreve_reg_id & valido_id;
      usa_imm_d = usa_imediato_id;
      imm_d     = imediato_id;
      sinal_d   = sinal_dec;
    end
  end

  // Pipeline register with synchronous reset to a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      valido_q  <= 1'b0;
      dado1_q   <= '0;
      dado2_q   <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      escreve_q <= 1'b0;
      usa_imm_q <= 1'b0;
      imm_q     <= '0;
      sinal_q   <= '0;
    end else begin
      valido_q  <= valido_d;
      dado1_q   <= dado1_d;
      dado2_q   <= dado2_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      escreve_q <= escreve_d;
      usa_imm_q <= usa_imm_d;
      imm_q     <= imm_d;
      sinal_q   <= sinal_d;
    end
  end

  assign entrada1       = fwd1;
  assign entrada2       = usa_imm_q ? {{(LARGURA-4){imm_q[3]}}, imm_q} : fwd2;
  assign sinal_ula      = sinal_q;
  assign valido_ex      = valido_q;
  assign rd_ex          = rd_q;
  assign escreve_reg_ex = escreve_q;

endmodule
